// File: rtl/conf_output_arbiter.sv
// Configuration-output arbiter: NUM_CH requesters, each buffered by its own FIFO,
// merged onto one registered c_addr/c_data/c_valid/c_ready port.
// Supports round-robin or fixed-priority (lowest index) selection.
module conf_output_arbiter #(
    parameter int c_addr_WIDTH = 8,
    parameter int c_data_WIDTH = 32,
    parameter int NUM_CH       = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int ARB_MODE     = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                ch_valid,
    output logic [NUM_CH-1:0]                ch_ready,
    input  logic [NUM_CH*c_addr_WIDTH-1:0]   ch_addr,
    input  logic [NUM_CH*c_data_WIDTH-1:0]   ch_data,
    output logic                             c_valid,
    output logic [c_addr_WIDTH-1:0]          c_addr,
    output logic [c_data_WIDTH-1:0]          c_data,
    output logic [$clog2(NUM_CH)-1:0]        c_ch,
    input  logic                             c_ready
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = c_addr_WIDTH + c_data_WIDTH;

    logic [ENT_W-1:0]        r_mem  [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wptr [NUM_CH];
    logic [PTR_W-1:0]        r_rptr [NUM_CH];
    logic [CNT_W-1:0]        r_cnt  [NUM_CH];
    logic [CH_W-1:0]         r_rr_ptr;
    logic                    r_c_valid;
    logic [c_addr_WIDTH-1:0] r_c_addr;
    logic [c_data_WIDTH-1:0] r_c_data;
    logic [CH_W-1:0]         r_c_ch;

    logic [NUM_CH-1:0]       w_nonempty;
    logic [NUM_CH-1:0]       w_push;
    logic [NUM_CH-1:0]       w_pop;
    logic                    w_load;
    logic                    w_gnt_vld;
    logic [CH_W-1:0]         w_gnt;
    logic [ENT_W-1:0]        w_head;

    // The output register may take a new word when it is empty or being drained.
    assign w_load  = !r_c_valid || c_ready;
    assign w_head  = r_mem[w_gnt][r_rptr[w_gnt]];

    assign c_valid = r_c_valid;
    assign c_addr  = r_c_addr;
    assign c_data  = r_c_data;
    assign c_ch    = r_c_ch;

    // Per-channel status from registered counts only; a same-cycle pop never frees a slot.
    always_comb begin
        ch_ready   = '0;
        w_nonempty = '0;
        w_push     = '0;
        w_pop      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_nonempty[i] = (r_cnt[i] != '0);
            ch_ready[i]   = (r_cnt[i] < CNT_W'(FIFO_DEPTH));
            w_push[i]     = ch_valid[i] && ch_ready[i];
            w_pop[i]      = w_load && w_gnt_vld && (w_gnt == CH_W'(i));
        end
    end

    // Grant selection: lowest non-empty index, or first non-empty from rr_ptr onward.
    always_comb begin
        int idx;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        idx       = 0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (w_nonempty[i]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = CH_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = (int'(r_rr_ptr) + k) % NUM_CH;
                if (!w_gnt_vld && w_nonempty[idx]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = CH_W'(idx);
                end
            end
        end
    end

    // FIFO storage writes; contents need no reset since counts gate every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_push[i])
                r_mem[i][r_wptr[i]] <= {ch_addr[i*c_addr_WIDTH +: c_addr_WIDTH],
                                        ch_data[i*c_data_WIDTH +: c_data_WIDTH]};
        end
    end

    // FIFO pointers and counts; push and pop together leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_push[i])
                    r_wptr[i] <= r_wptr[i] + 1'b1;
                if (w_pop[i])
                    r_rptr[i] <= r_rptr[i] + 1'b1;
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    // Round-robin pointer moves just past the granted channel, wrapping at NUM_CH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rr_ptr <= '0;
        else if (ARB_MODE == 0 && w_load && w_gnt_vld)
            r_rr_ptr <= (w_gnt == CH_W'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
    end

    // Output register: loads the granted head, holds everything while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_valid <= 1'b0;
            r_c_addr  <= '0;
            r_c_data  <= '0;
            r_c_ch    <= '0;
        end else if (w_load) begin
            r_c_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_c_addr <= w_head[ENT_W-1 -: c_addr_WIDTH];
                r_c_data <= w_head[c_data_WIDTH-1:0];
                r_c_ch   <= w_gnt;
            end
        end
    end

endmodule

// File: tb/tb_conf_output_arbiter.sv
// Bench for conf_output_arbiter: a round-robin and a fixed-priority instance share
// the same stimulus and are each compared against a queue-based reference model.
module tb_conf_output_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   ch_valid;
    logic [31:0]  ch_addr;
    logic [127:0] ch_data;
    logic         c_ready;

    logic [1:0]   o_valid;
    logic [7:0]   o_addr  [2];
    logic [31:0]  o_data  [2];
    logic [1:0]   o_ch    [2];
    logic [3:0]   o_rdy   [2];

    conf_output_arbiter #(.c_addr_WIDTH(8), .c_data_WIDTH(32), .NUM_CH(4),
                          .FIFO_DEPTH(4), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(o_rdy[0]),
        .ch_addr(ch_addr), .ch_data(ch_data), .c_valid(o_valid[0]),
        .c_addr(o_addr[0]), .c_data(o_data[0]), .c_ch(o_ch[0]), .c_ready(c_ready));

    conf_output_arbiter #(.c_addr_WIDTH(8), .c_data_WIDTH(32), .NUM_CH(4),
                          .FIFO_DEPTH(4), .ARB_MODE(1)) u_fp (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(o_rdy[1]),
        .ch_addr(ch_addr), .ch_data(ch_data), .c_valid(o_valid[1]),
        .c_addr(o_addr[1]), .c_data(o_data[1]), .c_ch(o_ch[1]), .c_ready(c_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: one queue per (mode, channel), plus the output word per mode.
    logic [39:0] mq [8][$];
    bit          mv  [2];
    logic [7:0]  ma  [2];
    logic [31:0] md  [2];
    int          mch [2];
    int          mrr [2];

    // Completed output transfers per instance: {ch, addr, data}.
    logic [41:0] tlog [2][$];

    typedef struct {
        logic [3:0]  vld;
        logic [7:0]  a;
        logic [31:0] d;
        logic        rdy;
        logic        ev;
        logic [7:0]  ea;
        logic [31:0] ed;
        logic [1:0]  ech;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int q = 0; q < 8; q++) mq[q].delete();
        for (int m = 0; m < 2; m++) begin
            mv[m] = 0; ma[m] = '0; md[m] = '0; mch[m] = 0; mrr[m] = 0;
        end
    endtask

    task automatic model_step();
        bit rdy [4];
        bit load;
        int g;
        int idx;
        logic [39:0] w;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) rdy[c] = (mq[m*4+c].size() < 4);
            load = !mv[m] || c_ready;
            if (load) begin
                g = -1;
                for (int k = 0; k < 4; k++) begin
                    idx = (m == 0) ? (mrr[m] + k) % 4 : k;
                    if (g < 0 && mq[m*4+idx].size() > 0) g = idx;
                end
                if (g >= 0) begin
                    w = mq[m*4+g].pop_front();
                    mv[m] = 1; ma[m] = w[39:32]; md[m] = w[31:0]; mch[m] = g;
                    if (m == 0) mrr[m] = (g + 1) % 4;
                end else begin
                    mv[m] = 0;
                end
            end
            for (int c = 0; c < 4; c++)
                if (ch_valid[c] && rdy[c])
                    mq[m*4+c].push_back({ch_addr[c*8 +: 8], ch_data[c*32 +: 32]});
        end
    endtask

    task automatic model_check();
        logic [3:0] er;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d_valid", m), 64'(o_valid[m]), 64'(mv[m]));
            if (mv[m]) begin
                check($sformatf("m%0d_addr", m), 64'(o_addr[m]), 64'(ma[m]));
                check($sformatf("m%0d_data", m), 64'(o_data[m]), 64'(md[m]));
                check($sformatf("m%0d_ch", m),   64'(o_ch[m]),   64'(mch[m]));
            end
            for (int c = 0; c < 4; c++) er[c] = (mq[m*4+c].size() < 4);
            check($sformatf("m%0d_ch_ready", m), 64'(o_rdy[m]), 64'(er));
        end
    endtask

    // One clock: log transfers, advance model, sample #1 after the edge, compare.
    task automatic cycle();
        for (int m = 0; m < 2; m++)
            if (o_valid[m] && c_ready) tlog[m].push_back({o_ch[m], o_addr[m], o_data[m]});
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        rst = 1'b1; ch_valid = '0; ch_addr = '0; ch_data = '0; c_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tlog[0].delete();
        tlog[1].delete();
    endtask

    vec_t tbl [12];
    int   acc, nxt, bad, n3;
    bit   took, seen3;

    initial begin
        rst = 1'b1; ch_valid = '0; ch_addr = '0; ch_data = '0; c_ready = 1'b0;
        model_reset();

        // single transfer, then backpressure hold of 5 cycles
        tbl[0]  = '{4'b0100, 8'h15, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 32'h0, 2'd0};
        tbl[1]  = '{4'b0000, 8'h00, 32'h0,        1'b1, 1'b1, 8'h15, 32'hDEADBEEF, 2'd2};
        tbl[2]  = '{4'b0000, 8'h00, 32'h0,        1'b1, 1'b0, 8'h00, 32'h0, 2'd0};
        tbl[3]  = '{4'b0100, 8'h2A, 32'h12345678, 1'b0, 1'b0, 8'h00, 32'h0, 2'd0};
        tbl[4]  = '{4'b0000, 8'h00, 32'h0,        1'b0, 1'b1, 8'h2A, 32'h12345678, 2'd2};
        for (int i = 5; i < 10; i++)
            tbl[i] = '{4'b0000, 8'h00, 32'h0,     1'b0, 1'b1, 8'h2A, 32'h12345678, 2'd2};
        tbl[10] = '{4'b0000, 8'h00, 32'h0,        1'b1, 1'b0, 8'h00, 32'h0, 2'd0};
        tbl[11] = '{4'b0000, 8'h00, 32'h0,        1'b1, 1'b0, 8'h00, 32'h0, 2'd0};

        do_reset();
        check("reset_valid", 64'(o_valid), 64'h0);
        check("reset_addr",  64'(o_addr[0]), 64'h0);
        check("reset_data",  64'(o_data[0]), 64'h0);
        check("reset_ch",    64'(o_ch[0]), 64'h0);
        check("reset_ready", 64'({o_rdy[1], o_rdy[0]}), 64'hFF);

        for (int i = 0; i < 12; i++) begin
            ch_valid = tbl[i].vld;
            ch_addr  = {4{tbl[i].a}};
            ch_data  = {4{tbl[i].d}};
            c_ready  = tbl[i].rdy;
            cycle();
            check($sformatf("tbl%0d_valid", i), 64'(o_valid[0]), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_addr", i), 64'(o_addr[0]), 64'(tbl[i].ea));
                check($sformatf("tbl%0d_data", i), 64'(o_data[0]), 64'(tbl[i].ed));
                check($sformatf("tbl%0d_ch", i),   64'(o_ch[0]),   64'(tbl[i].ech));
            end
        end
        check("bp_transfers", 64'(tlog[0].size()), 64'd2);

        // round-robin fairness: two words per channel, then drain
        do_reset();
        for (int w = 0; w < 2; w++) begin
            ch_valid = 4'hF;
            for (int c = 0; c < 4; c++) begin
                ch_addr[c*8 +: 8]   = 8'(16 * c + w);
                ch_data[c*32 +: 32] = 32'hC0DE0000 + 32'(256 * c + w);
            end
            cycle();
        end
        ch_valid = '0; c_ready = 1'b1;
        repeat (12) cycle();
        check("rr_count", 64'(tlog[0].size()), 64'd8);
        for (int i = 0; i < 8 && i < tlog[0].size(); i++)
            check($sformatf("rr_word%0d", i), 64'(tlog[0][i]),
                  64'({2'(i % 4), 8'(16 * (i % 4) + i / 4), 32'hC0DE0000 + 32'(256 * (i % 4) + i / 4)}));

        // FIFO full on channel 1 with the output stalled
        do_reset();
        acc = 0; nxt = 0;
        for (int k = 0; k < 10; k++) begin
            ch_valid = 4'b0010;
            ch_addr  = {16'h0, 8'(8'h40 + nxt), 8'h0};
            ch_data  = {64'h0, 32'(nxt), 32'h0};
            took = o_rdy[0][1];
            cycle();
            if (took) begin acc++; nxt++; end
        end
        check("full_accepted", 64'(acc), 64'd5);
        check("full_ready_low", 64'(o_rdy[0][1]), 64'd0);
        ch_valid = '0; c_ready = 1'b1;
        repeat (10) cycle();
        check("full_drained", 64'(tlog[0].size()), 64'd5);
        for (int i = 0; i < 5 && i < tlog[0].size(); i++)
            check($sformatf("full_word%0d", i), 64'(tlog[0][i]),
                  64'({2'd1, 8'(8'h40 + i), 32'(i)}));

        // fixed priority: ch 0 and ch 3 both streaming
        do_reset();
        c_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            ch_valid = 4'b1001;
            ch_addr  = {8'(8'h30 + k), 16'h0, 8'(k)};
            ch_data  = {32'(32'h3000 + k), 64'h0, 32'(k)};
            cycle();
        end
        bad = 0;
        foreach (tlog[1][i]) if (tlog[1][i][41:40] != 2'd0) bad++;
        check("fp_only_ch0", 64'(bad), 64'd0);
        check("fp_busy", 64'(tlog[1].size() >= 10), 64'd1);
        tlog[1].delete();
        ch_valid = '0;
        repeat (10) cycle();
        bad = 0; n3 = 0; seen3 = 0;
        foreach (tlog[1][i]) begin
            if (tlog[1][i][41:40] == 2'd3) begin seen3 = 1; n3++; end
            else if (seen3) bad++;
        end
        check("fp_ch3_after_ch0", 64'(bad), 64'd0);
        check("fp_ch3_granted", 64'(n3), 64'd4);

        // reset while a word is held and three FIFOs hold data
        do_reset();
        for (int k = 0; k < 2; k++) begin
            ch_valid = 4'b0111;
            ch_addr  = {8'h0, 8'(8'h20 + k), 8'(8'h10 + k), 8'(k)};
            ch_data  = {32'h0, 32'hA0 + 32'(k), 32'hB0 + 32'(k), 32'hC0 + 32'(k)};
            cycle();
        end
        check("mid_valid_before", 64'(o_valid[0]), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("mid_valid_async", 64'(o_valid), 64'd0);
        check("mid_ready_async", 64'({o_rdy[1], o_rdy[0]}), 64'hFF);
        ch_valid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tlog[0].delete(); tlog[1].delete();
        c_ready = 1'b1;
        repeat (10) cycle();
        check("mid_no_stale_rr", 64'(tlog[0].size()), 64'd0);
        check("mid_no_stale_fp", 64'(tlog[1].size()), 64'd0);

        // randomized traffic with bursty backpressure
        do_reset();
        for (int k = 0; k < 400; k++) begin
            ch_valid = 4'($urandom);
            ch_addr  = $urandom;
            ch_data  = {$urandom, $urandom, $urandom, $urandom};
            c_ready  = ((k / 40) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
